// File: rtl/brick_game_ctrl.sv
// Brick breaker game sequencer: state machine, movement tick, per-tick enables
// and the lives / score / bricks_left counters that drive the overlay.
module brick_game_ctrl #(
    parameter int TICK_DIV    = 277777,
    parameter int LIVES       = 3,
    parameter int NUM_BRICKS  = 40,
    parameter int SERVE_TICKS = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        brick_hit,
    input  logic        ball_missed,
    output logic [2:0]  state,
    output logic        paddle_en,
    output logic        ball_en,
    output logic        ball_reset,
    output logic [3:0]  lives,
    output logic [15:0] score,
    output logic [7:0]  bricks_left
);

    localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5
    } state_t;

    state_t        st, st_nxt;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          start_q, start_edge;
    logic [7:0]    serve_cnt, serve_nxt;
    logic [3:0]    lives_nxt;
    logic [15:0]   score_nxt;
    logic [7:0]    bricks_nxt;

    // Free-running tick; its phase is independent of game state.
    assign tick = (tick_cnt == TW'(TICK_DIV));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            start_q  <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            start_q  <= start;
        end
    end

    assign start_edge = start & ~start_q;

    always_comb begin
        st_nxt     = st;
        serve_nxt  = serve_cnt;
        lives_nxt  = lives;
        score_nxt  = score;
        bricks_nxt = bricks_left;
        case (st)
            S_IDLE: begin
                lives_nxt  = 4'(LIVES);
                score_nxt  = '0;
                bricks_nxt = 8'(NUM_BRICKS);
                if (start_edge) begin
                    st_nxt    = S_SERVE;
                    serve_nxt = '0;
                end
            end
            S_SERVE: begin
                if (tick) begin
                    serve_nxt = serve_cnt + 8'd1;
                    if (serve_cnt == 8'(SERVE_TICKS - 1))
                        st_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (brick_hit) begin
                    if (score != 16'hFFFF)
                        score_nxt = score + 16'd1;
                    bricks_nxt = bricks_left - 8'd1;
                end
                // Final brick wins even when the ball is lost on the same cycle.
                if (brick_hit && bricks_left == 8'd1)
                    st_nxt = S_WIN;
                else if (ball_missed)
                    st_nxt = S_MISS;
            end
            S_MISS: begin
                lives_nxt = lives - 4'd1;
                if (lives == 4'd1) begin
                    st_nxt = S_OVER;
                end else begin
                    st_nxt    = S_SERVE;
                    serve_nxt = '0;
                end
            end
            S_OVER, S_WIN: begin
                if (start_edge) begin
                    lives_nxt  = 4'(LIVES);
                    score_nxt  = '0;
                    bricks_nxt = 8'(NUM_BRICKS);
                    serve_nxt  = '0;
                    st_nxt     = S_SERVE;
                end
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_IDLE;
            serve_cnt   <= '0;
            lives       <= 4'(LIVES);
            score       <= '0;
            bricks_left <= 8'(NUM_BRICKS);
            ball_reset  <= 1'b1;
        end else begin
            st          <= st_nxt;
            serve_cnt   <= serve_nxt;
            lives       <= lives_nxt;
            score       <= score_nxt;
            bricks_left <= bricks_nxt;
            ball_reset  <= (st_nxt != S_PLAY);
        end
    end

    assign state     = st;
    assign paddle_en = tick & ((st == S_SERVE) | (st == S_PLAY));
    assign ball_en   = tick & (st == S_PLAY);

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Bench for brick_game_ctrl: directed game scenarios plus random play, all
// checked every cycle against a cycle-count based game model.
module tb_brick_game_ctrl;

    localparam int TD = 3, LV = 2, NB = 3, ST = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0, brick_hit = 1'b0, ball_missed = 1'b0;
    logic [2:0]  state;
    logic        paddle_en, ball_en, ball_reset;
    logic [3:0]  lives;
    logic [15:0] score;
    logic [7:0]  bricks_left;

    brick_game_ctrl #(.TICK_DIV(TD), .LIVES(LV), .NUM_BRICKS(NB), .SERVE_TICKS(ST)) dut (
        .clk(clk), .rst(rst), .start(start), .brick_hit(brick_hit),
        .ball_missed(ball_missed), .state(state), .paddle_en(paddle_en),
        .ball_en(ball_en), .ball_reset(ball_reset), .lives(lives),
        .score(score), .bricks_left(bricks_left)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    // game model: m_cyc counts clock edges since reset, so the tick is a pure
    // function of elapsed cycles
    int m_state, m_lives, m_score, m_bricks, m_serve, m_cyc;
    bit m_start_q;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = LV; m_score = 0; m_bricks = NB;
        m_serve = 0; m_cyc = 0; m_start_q = 0;
    endtask

    function automatic bit m_tick();
        return (m_cyc % (TD + 1)) == TD;
    endfunction

    task automatic model_edge(input bit s, input bit h, input bit m);
        bit tk, edge_s;
        tk = m_tick();
        edge_s = s && !m_start_q;
        case (m_state)
            0: if (edge_s) begin m_state = 1; m_serve = 0; end
            1: if (tk) begin
                   m_serve++;
                   if (m_serve == ST) m_state = 2;
               end
            2: begin
                   if (h) begin
                       if (m_score < 65535) m_score++;
                       m_bricks--;
                   end
                   if (h && m_bricks == 0) m_state = 5;
                   else if (m) m_state = 3;
               end
            3: begin
                   m_lives--;
                   m_state = (m_lives == 0) ? 4 : 1;
                   m_serve = 0;
               end
            default: if (edge_s) begin
                   m_state = 1; m_lives = LV; m_score = 0; m_bricks = NB; m_serve = 0;
               end
        endcase
        m_start_q = s;
        m_cyc++;
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("lives", lives, m_lives);
        chk("score", score, m_score);
        chk("bricks_left", bricks_left, m_bricks);
        chk("ball_reset", ball_reset, m_state != 2);
        chk("paddle_en", paddle_en, m_tick() && (m_state == 1 || m_state == 2));
        chk("ball_en", ball_en, m_tick() && m_state == 2);
    endtask

    task automatic step(input bit s, input bit h, input bit m);
        start = s; brick_hit = h; ball_missed = m;
        @(posedge clk);
        model_edge(s, h, m);
        @(negedge clk);
        start = 0; brick_hit = 0; ball_missed = 0;
        check_all();
    endtask

    task automatic run_until(input int target, input int budget);
        for (int i = 0; i < budget && m_state != target; i++) step(0, 0, 0);
        chk("reach_state", state, target);
    endtask

    task automatic new_game();
        step(1, 0, 0);
        step(0, 0, 0);
        run_until(2, 20);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_state", state, 0);
        chk("rst_lives", lives, LV);
        chk("rst_score", score, 0);
        chk("rst_bricks", bricks_left, NB);
        chk("rst_ball_reset", ball_reset, 1);
        chk("rst_paddle_en", paddle_en, 0);
        @(negedge clk);
        rst = 0;

        // start held for 10 cycles: single serve, play on the 2nd tick
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        chk("held_start_play", state, 2);
        for (int i = 0; i < 8; i++) step(0, 0, 0);

        // win path, then a late hit is ignored
        for (int i = 0; i < 3; i++) begin step(0, 1, 0); step(0, 0, 0); end
        chk("win_state", state, 5);
        chk("win_score", score, 3);
        step(0, 1, 0);
        chk("win_late_hit", score, 3);

        // simultaneous final hit and miss
        new_game();
        step(0, 1, 0); step(0, 1, 0);
        step(0, 1, 1);
        chk("final_hit_miss_state", state, 5);
        chk("final_hit_miss_lives", lives, LV);

        // lives and game over
        new_game();
        step(0, 0, 1);
        chk("miss_state", state, 3);
        step(0, 0, 0);
        chk("after_miss_state", state, 1);
        chk("after_miss_lives", lives, 1);
        step(0, 1, 1);              // ignored in SERVE
        run_until(2, 20);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("over_state", state, 4);
        chk("over_lives", lives, 0);
        step(0, 1, 0); step(0, 0, 1);  // ignored in OVER
        step(1, 0, 0);
        chk("restart_state", state, 1);
        chk("restart_lives", lives, LV);

        // asynchronous reset mid-PLAY with score 1
        run_until(2, 20);
        step(0, 1, 0);
        #2 rst = 1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_lives", lives, LV);
        chk("arst_score", score, 0);
        chk("arst_bricks", bricks_left, NB);
        #1 rst = 0;
        model_reset();
        step(0, 1, 0); step(0, 0, 1);  // ignored in IDLE

        // random play
        for (int i = 0; i < 1500; i++)
            step(($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 9) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
